// File: rtl/scazator_serial.sv
`timescale 1ns/1ps
// scazator_serial: bit-serial subtractor computing a - b - bin, LSB first.
// One full-subtractor bit slice and one borrow flop are reused over WIDTH
// cycles. The handshake is start/busy/done. diff and bout hold their last
// completed value until the next completion or until reset.
module scazator_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, a_sh_next;
  logic [WIDTH-1:0] b_sh_reg, b_sh_next;
  logic [WIDTH-1:0] res_sh_reg, res_sh_next;
  logic [WIDTH-1:0] diff_reg, diff_next;
  logic             borrow_reg, borrow_next;
  logic             bout_reg, bout_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  // Outputs of the single full-subtractor bit slice.
  logic             slice_d;
  logic             slice_b;
  // Result register after this cycle's shift. The new bit enters at the MSB.
  logic [WIDTH-1:0] res_shift;

  // Full-subtractor slice on the current LSBs and the stored borrow.
  always_comb begin
    slice_d = a_sh_reg[0] ^ b_sh_reg[0] ^ borrow_reg;
    slice_b = (~a_sh_reg[0] & b_sh_reg[0]) |
              (~(a_sh_reg[0] ^ b_sh_reg[0]) & borrow_reg);
  end

  // Result shifter. After WIDTH shifts, bit 0 of the operands sits in bit 0
  // of the result.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_res_shift
      assign res_shift[gi] = res_sh_reg[gi+1];
    end
  endgenerate
  assign res_shift[WIDTH-1] = slice_d;

  // Next-state and datapath next values. Every _next value defaults to a hold.
  always_comb begin
    state_next  = state_reg;
    a_sh_next   = a_sh_reg;
    b_sh_next   = b_sh_reg;
    res_sh_next = res_sh_reg;
    borrow_next = borrow_reg;
    cnt_next    = cnt_reg;
    diff_next   = diff_reg;
    bout_next   = bout_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = RUN;
          a_sh_next   = a;
          b_sh_next   = b;
          borrow_next = bin;
          cnt_next    = '0;
          res_sh_next = '0;
        end
      end
      RUN: begin
        a_sh_next   = a_sh_reg >> 1;
        b_sh_next   = b_sh_reg >> 1;
        borrow_next = slice_b;
        res_sh_next = res_shift;
        if (cnt_reg == LAST) begin
          // Last bit: publish the finished result and the borrow together.
          // The counter holds here and does not wrap.
          state_next = DONE;
          diff_next  = res_shift;
          bout_next  = slice_b;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Status flags are computed from the next state so they come from flops.
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  // State register and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Datapath registers. Reset clears everything, including published results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
    end else begin
      a_sh_reg   <= a_sh_next;
      b_sh_reg   <= b_sh_next;
      res_sh_reg <= res_sh_next;
      borrow_reg <= borrow_next;
      cnt_reg    <= cnt_next;
      diff_reg   <= diff_next;
      bout_reg   <= bout_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign diff = diff_reg;
  assign bout = bout_reg;

endmodule
